// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mc_ctrl_pkg;

  // Control FSM states; 15 of the 16 codes are used, the spare code traps.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_UEXEC   = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_LINK    = 4'd12,
    S_BRANCH  = 4'd13,
    S_TRAP    = 4'd14
  } state_t;

  // RV32I major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALUOp: what the ALU decoder should produce
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Bit positions inside the {V,C,N,Z} flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Immediate format implied by the opcode; R-type has no immediate and
  // falls into the I default, which is harmless.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] f;
    f = IMM_I;
    case (op)
      OP_STORE:         f = IMM_S;
      OP_BRANCH:        f = IMM_B;
      OP_JAL:           f = IMM_J;
      OP_LUI, OP_AUIPC: f = IMM_U;
      default:          f = IMM_I;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus funct fields to an ALUControl code.
// Latency: purely combinational.
// Backpressure: none.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] aluop,
  output logic [3:0] alu_control
);

  // Fixed add/sub for address and branch work, funct decode for ALU ops
  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // sub only exists for register-register; addi ignores funct7
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          // srai also carries funct7b5, so no op5 qualification here
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM over a shared ALU and unified memory.
// Latency: 3-5 cycles per instruction plus one per memory wait cycle.
// Backpressure: holds FETCH/MEMRD/MEMWR while mem_ready is low; MEM_TIMEOUT_EN adds a bus-fault trap.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] flags,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       instr_done,
  output logic       trap,
  output logic       bus_fault
);

  // The wait counter cannot reach a limit wider than itself
  if (MEM_TIMEOUT >= (1 << TIMEOUT_W)) begin : g_timeout_range
    $error("MEM_TIMEOUT does not fit in TIMEOUT_W bits");
  end

  state_t     state, state_nxt;
  logic [1:0] aluop;
  logic       taken, branch_ok;
  logic       mem_state, timeout;
  logic       req_raw, mw_raw, irw_raw, pcw_raw, rw_raw, done_raw;

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign ImmSrc    = imm_src_of(op);

  alu_decoder u_alu_decoder (
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .aluop       (aluop),
    .alu_control (ALUControl)
  );

`ifdef MEM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wait_cnt;

  // Completion in the limit cycle beats the timeout, hence the !mem_ready term
  assign timeout = mem_state && !mem_ready && (wait_cnt == TIMEOUT_W'(MEM_TIMEOUT));

  // Count stalled request cycles; anything else restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (mem_state && !mem_ready && !timeout) begin
      wait_cnt <= wait_cnt + TIMEOUT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Trap cause latches with the trap and is only cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_fault <= 1'b0;
    end else if (timeout) begin
      bus_fault <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign bus_fault = 1'b0;
`endif

  // Branch condition from the subtract flags; C set means no borrow
  always_comb begin
    taken     = 1'b0;
    branch_ok = 1'b1;
    case (funct3)
      3'b000:  taken = flags[FLAG_Z];
      3'b001:  taken = !flags[FLAG_Z];
      3'b100:  taken = flags[FLAG_N] ^ flags[FLAG_V];
      3'b101:  taken = !(flags[FLAG_N] ^ flags[FLAG_V]);
      3'b110:  taken = !flags[FLAG_C];
      3'b111:  taken = flags[FLAG_C];
      default: branch_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_nxt = state;
    req_raw   = 1'b0;
    mw_raw    = 1'b0;
    irw_raw   = 1'b0;
    pcw_raw   = 1'b0;
    rw_raw    = 1'b0;
    done_raw  = 1'b0;
    trap      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    aluop     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        // PC+4 goes straight to PC while the instruction is captured
        req_raw   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        irw_raw   = mem_ready;
        pcw_raw   = mem_ready;
        if (mem_ready)    state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_TRAP;
      end
      S_DECODE: begin
        // Precompute OldPC+imm so branch/JAL targets sit in ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_LUI, OP_AUIPC:  state_nxt = S_UEXEC;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_BRANCH:         state_nxt = S_BRANCH;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        req_raw = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready)    state_nxt = S_MEMWB;
        else if (timeout) state_nxt = S_TRAP;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        rw_raw    = 1'b1;
        done_raw  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        // Address and write strobe stay put for every wait cycle
        req_raw  = 1'b1;
        AdrSrc   = 1'b1;
        mw_raw   = 1'b1;
        done_raw = mem_ready;
        if (mem_ready)    state_nxt = S_FETCH;
        else if (timeout) state_nxt = S_TRAP;
      end
      S_EXECR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        aluop     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        aluop     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_UEXEC: begin
        // LUI adds the immediate to zero, AUIPC to the instruction's PC
        ALUSrcA   = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        rw_raw    = 1'b1;
        done_raw  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        // Target from DECODE is in ALUOut; ALU meanwhile forms the link
        ResultSrc = RES_ALUOUT;
        pcw_raw   = 1'b1;
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        state_nxt = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        pcw_raw   = 1'b1;
        state_nxt = S_LINK;
      end
      S_LINK: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        state_nxt = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        aluop     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        pcw_raw   = taken && branch_ok;
        done_raw  = branch_ok;
        state_nxt = branch_ok ? S_FETCH : S_TRAP;
      end
      default: begin
        // TRAP and the unused encoding: absorbing, no strobes
        trap      = 1'b1;
        state_nxt = S_TRAP;
      end
    endcase
  end

  // Strobes are suppressed for the whole reset cycle so an abandoned
  // access never writes
  assign mem_req    = req_raw  && !reset;
  assign MemWrite   = mw_raw   && !reset;
  assign IRWrite    = irw_raw  && !reset;
  assign PCWrite    = pcw_raw  && !reset;
  assign RegWrite   = rw_raw   && !reset;
  assign instr_done = done_raw && !reset;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam int TO = 3;
`ifdef MEM_TIMEOUT_EN
  localparam int MAXW = TO;
`else
  localparam int MAXW = 6;
`endif

  localparam logic [6:0] O_LD = 7'b0000011, O_ST = 7'b0100011, O_R = 7'b0110011,
                         O_I = 7'b0010011, O_LUI = 7'b0110111, O_AUI = 7'b0010111,
                         O_JAL = 7'b1101111, O_JALR = 7'b1100111, O_BR = 7'b1100011;
  localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4, A_SLT = 5,
                 A_SLL = 6, A_SRL = 7, A_SRA = 8, A_SLTU = 9;
  // strobes, instr_done, trap, bus_fault
  localparam logic [18:0] M_ALWAYS = 19'b1_0_1_1_1_1_00_00_00_0000_1_1_1;
  // strobes and instr_done only
  localparam logic [18:0] M_RESET  = 19'b1_0_1_1_1_1_00_00_00_0000_1_0_0;

  logic       clk = 1'b0;
  logic       reset, funct7b5, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [3:0] flags;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       instr_done, trap, bus_fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rdy;
    logic [18:0] exp;
    logic [18:0] msk;
    int          imm;
    string       nm;
  } cyc_t;
  cyc_t q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(TO), .TIMEOUT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .flags(flags), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .instr_done(instr_done), .trap(trap), .bus_fault(bus_fault)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [18:0] obs_vec();
    return {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ALUControl, instr_done, trap, bus_fault};
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Expected ALU operation from the RV32I funct fields
  function automatic int alu_ref(input bit is_r, input logic [2:0] f3, input bit f7);
    case (f3)
      3'd0: return (is_r && f7) ? A_SUB : A_ADD;
      3'd1: return A_SLL;
      3'd2: return A_SLT;
      3'd3: return A_SLTU;
      3'd4: return A_XOR;
      3'd5: return f7 ? A_SRA : A_SRL;
      3'd6: return A_OR;
      default: return A_AND;
    endcase
  endfunction

  function automatic int imm_ref(input logic [6:0] o);
    case (o)
      O_LD, O_I, O_JALR: return 0;
      O_ST:              return 1;
      O_BR:              return 2;
      O_JAL:             return 3;
      O_LUI, O_AUI:      return 4;
      default:           return -1;
    endcase
  endfunction

  // One expected cycle; -1 in any field means "not checked"
  task automatic put(input string nm, input bit rdy, input int mreq, input int adr,
                     input int mw, input int irw, input int pcw, input int rw,
                     input int done, input int rs, input int sa, input int sb,
                     input int alu, input int imm = -1);
    cyc_t c;
    c.nm = nm; c.rdy = rdy; c.imm = imm; c.exp = '0; c.msk = M_ALWAYS;
    if (mreq >= 0) c.exp[18] = mreq[0]; else c.msk[18] = 1'b0;
    if (adr  >= 0) begin c.exp[17] = adr[0]; c.msk[17] = 1'b1; end
    if (mw   >= 0) c.exp[16] = mw[0];   else c.msk[16] = 1'b0;
    if (irw  >= 0) c.exp[15] = irw[0];  else c.msk[15] = 1'b0;
    if (pcw  >= 0) c.exp[14] = pcw[0];  else c.msk[14] = 1'b0;
    if (rw   >= 0) c.exp[13] = rw[0];   else c.msk[13] = 1'b0;
    if (rs   >= 0) begin c.exp[12:11] = rs[1:0]; c.msk[12:11] = 2'b11; end
    if (sa   >= 0) begin c.exp[10:9]  = sa[1:0]; c.msk[10:9]  = 2'b11; end
    if (sb   >= 0) begin c.exp[8:7]   = sb[1:0]; c.msk[8:7]   = 2'b11; end
    if (alu  >= 0) begin c.exp[6:3]   = alu[3:0]; c.msk[6:3]  = 4'hf; end
    if (done >= 0) c.exp[2] = done[0];  else c.msk[2] = 1'b0;
    q.push_back(c);
  endtask

  task automatic put_trap(input bit rdy, input bit bf);
    cyc_t c;
    c.nm = "TRAP"; c.rdy = rdy; c.imm = -1; c.msk = M_ALWAYS;
    c.exp = '0; c.exp[1] = 1'b1; c.exp[0] = bf;
    q.push_back(c);
  endtask

  // Cycle-by-cycle expectation for one instruction, from the instruction's
  // documented micro-steps and wait counts
  task automatic build_instr(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                             input int tk, input int wf, input int wm);
    for (int i = 0; i < wf; i++) put("FETCH", 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2, A_ADD);
    put("FETCH", 1, 1, 0, 0, 1, 1, 0, 0, 2, 0, 2, A_ADD);
    put("DECODE", rb(), 0, -1, 0, 0, 0, 0, 0, -1, 1, 1, A_ADD, imm_ref(o));
    case (o)
      O_LD: begin
        put("MEMADR", rb(), 0, -1, 0, 0, 0, 0, 0, -1, 2, 1, A_ADD);
        for (int i = 0; i < wm; i++) put("MEMRD", 0, 1, 1, 0, 0, 0, 0, 0, -1, -1, -1, -1);
        put("MEMRD", 1, 1, 1, 0, 0, 0, 0, 0, -1, -1, -1, -1);
        put("MEMWB", rb(), 0, -1, 0, 0, 0, 1, 1, 1, -1, -1, -1);
      end
      O_ST: begin
        put("MEMADR", rb(), 0, -1, 0, 0, 0, 0, 0, -1, 2, 1, A_ADD);
        for (int i = 0; i < wm; i++) put("MEMWR", 0, 1, 1, 1, 0, 0, 0, 0, -1, -1, -1, -1);
        put("MEMWR", 1, 1, 1, 1, 0, 0, 0, 1, -1, -1, -1, -1);
      end
      O_R:   put("EXECR", rb(), 0, -1, 0, 0, 0, 0, 0, -1, 2, 0, alu_ref(1, f3, f7));
      O_I:   put("EXECI", rb(), 0, -1, 0, 0, 0, 0, 0, -1, 2, 1, alu_ref(0, f3, f7));
      O_LUI: put("UEXEC", rb(), 0, -1, 0, 0, 0, 0, 0, -1, 3, 1, A_ADD);
      O_AUI: put("UEXEC", rb(), 0, -1, 0, 0, 0, 0, 0, -1, 1, 1, A_ADD);
      O_JAL: put("JAL", rb(), 0, -1, 0, 0, 1, 0, 0, 0, 1, 2, A_ADD);
      O_JALR: begin
        put("JALR", rb(), 0, -1, 0, 0, 1, 0, 0, 2, 2, 1, A_ADD);
        put("LINK", rb(), 0, -1, 0, 0, 0, 0, 0, -1, 1, 2, A_ADD);
      end
      O_BR: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          put("BRANCH", rb(), 0, -1, 0, 0, -1, 0, -1, -1, 2, 0, A_SUB);
          repeat (3) put_trap(rb(), 0);
        end else begin
          put("BRANCH", rb(), 0, -1, 0, 0, tk, 0, 1, 0, 2, 0, A_SUB);
        end
      end
      default: repeat (3) put_trap(rb(), 0);
    endcase
    if (o == O_R || o == O_I || o == O_LUI || o == O_AUI || o == O_JAL || o == O_JALR)
      put("ALUWB", rb(), 0, -1, 0, 0, 0, 1, 1, 0, -1, -1, -1);
  endtask

  // Entered and left at posedge+1
  task automatic run_q();
    logic [18:0] o;
    for (int i = 0; i < q.size(); i++) begin
      mem_ready = q[i].rdy;
      @(negedge clk);
      o = obs_vec();
      total++;
      if ((o & q[i].msk) !== (q[i].exp & q[i].msk)) begin
        bad++;
        $display("FAIL cycle %0d (%s) op=%b f3=%b: got %b want %b mask %b",
                 i, q[i].nm, op, funct3, o, q[i].exp, q[i].msk);
      end
      if (q[i].imm >= 0) begin
        total++;
        if (ImmSrc !== q[i].imm[2:0]) begin
          bad++;
          $display("FAIL ImmSrc op=%b: got %0d want %0d", op, ImmSrc, q[i].imm);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                          input logic [3:0] fl, input int tk, input int wf, input int wm);
    op = o; funct3 = f3; funct7b5 = f7; flags = fl;
    q.delete();
    build_instr(o, f3, f7, tk, wf, wm);
    run_q();
  endtask

  // One reset edge with mem_ready high; no strobe may appear while reset is high
  task automatic apply_reset();
    logic [18:0] o;
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    o = obs_vec();
    total++;
    if ((o & M_RESET) !== 19'd0) begin
      bad++;
      $display("FAIL reset_strobes: got %b want zero under mask %b", o, M_RESET);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0; op = O_R; funct3 = 3'd0; funct7b5 = 1'b0; flags = 4'd0;
    @(posedge clk);
    #1;
    apply_reset();
  endtask

  task automatic test_add();
    do_instr(O_R, 3'b000, 1'b0, 4'h0, 0, 0, 0);
    do_instr(O_R, 3'b000, 1'b1, 4'h0, 0, 0, 0);
    do_instr(O_I, 3'b101, 1'b1, 4'h0, 0, 0, 0);
    do_instr(O_LUI, 3'b000, 1'b0, 4'h0, 0, 0, 0);
  endtask

  task automatic test_load_wait();
    do_instr(O_LD, 3'b010, 1'b0, 4'h0, 0, 0, 3);
    total++;
    if (q.size() != 8) begin
      bad++;
      $display("FAIL lw_length: got %0d cycles want 8", q.size());
    end
    do_instr(O_ST, 3'b010, 1'b0, 4'h0, 0, 2, 2);
  endtask

  task automatic test_branch();
    do_instr(O_BR, 3'b000, 1'b0, 4'b0001, 1, 0, 0);
    do_instr(O_BR, 3'b000, 1'b0, 4'b0000, 0, 0, 0);
    do_instr(O_BR, 3'b110, 1'b0, 4'b0000, 1, 0, 0);
    do_instr(O_BR, 3'b111, 1'b0, 4'b0000, 0, 0, 0);
  endtask

  task automatic test_jumps();
    do_instr(O_JALR, 3'b000, 1'b0, 4'h0, 0, 0, 0);
    do_instr(O_JAL, 3'b000, 1'b0, 4'h0, 0, 1, 0);
  endtask

  task automatic test_trap();
    op = 7'b0000000; funct3 = 3'd0; funct7b5 = 1'b0; flags = 4'h0;
    q.delete();
    build_instr(op, funct3, funct7b5, 0, 0, 0);
    repeat (17) put_trap(rb(), 0);
    run_q();
    apply_reset();
    do_instr(O_R, 3'b111, 1'b0, 4'h0, 0, 0, 0);
    do_instr(O_BR, 3'b010, 1'b0, 4'h0, 0, 0, 0);
    apply_reset();
    do_instr(O_AUI, 3'b000, 1'b0, 4'h0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    op = O_ST; funct3 = 3'b010; funct7b5 = 1'b0; flags = 4'h0;
    q.delete();
    build_instr(op, funct3, funct7b5, 0, 0, 4);
    repeat (3) void'(q.pop_back());
    run_q();
    apply_reset();
    do_instr(O_R, 3'b100, 1'b0, 4'h0, 0, 0, 0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    op = O_R; funct3 = 3'd0; funct7b5 = 1'b0; flags = 4'h0;
    q.delete();
    for (int i = 0; i <= TO; i++) put("FETCH", 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2, A_ADD);
    repeat (4) put_trap(rb(), 1);
    run_q();
    apply_reset();
    do_instr(O_R, 3'b000, 1'b0, 4'h0, 0, TO, 0);
    do_instr(O_LD, 3'b000, 1'b0, 4'h0, 0, 0, TO);
  endtask
`else
  task automatic test_no_timeout();
    do_instr(O_R, 3'b000, 1'b0, 4'h0, 0, 40, 0);
    do_instr(O_LD, 3'b000, 1'b0, 4'h0, 0, 0, 20);
  endtask
`endif

  task automatic test_random();
    logic [6:0] ops [9];
    int         lf  [6];
    ops = '{O_LD, O_ST, O_R, O_I, O_LUI, O_AUI, O_JAL, O_JALR, O_BR};
    lf  = '{0, 1, 4, 5, 6, 7};
    for (int n = 0; n < 60; n++) begin
      logic [6:0]  o;
      logic [2:0]  f3;
      logic [3:0]  fl;
      logic [31:0] a, b, d;
      int          tk;
      o  = ops[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      fl = 4'($urandom_range(0, 15));
      tk = 0;
      if (o == O_BR) begin
        f3 = 3'(lf[$urandom_range(0, 5)]);
        a  = $urandom;
        b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
        d  = a - b;
        fl = {(a[31] != b[31]) && (d[31] != a[31]), a >= b, d[31], d == 32'd0};
        case (f3)
          3'd0: tk = int'(a == b);
          3'd1: tk = int'(a != b);
          3'd4: tk = int'($signed(a) < $signed(b));
          3'd5: tk = int'($signed(a) >= $signed(b));
          3'd6: tk = int'(a < b);
          default: tk = int'(a >= b);
        endcase
      end
      do_instr(o, f3, rb(), fl, tk, $urandom_range(0, MAXW), $urandom_range(0, MAXW));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_jumps();
    test_trap();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control unit for the RISC-V core, the successor to the single-cycle `controller`. One FSM sequences each RV32I instruction over 3–5 states, sharing a single ALU and a unified instruction/data memory. Memory accesses use a ready/request handshake, so any number of wait states is allowed. Illegal opcodes, and memory timeouts when enabled, drive the FSM into a sticky trap state.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: wait cycles tolerated per memory access before a bus fault (used only with `MEM_TIMEOUT_EN`).
- `TIMEOUT_W`, default 8: width of the wait counter; must satisfy `MEM_TIMEOUT` < 2^`TIMEOUT_W`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7, `funct3` in 3, `funct7b5` in 1: fields from the instruction register.
- `flags` in 4: ALU flags {V,C,N,Z}, where `flags[0]`=Z and C=1 means no borrow.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access requested.
- `AdrSrc` out 1: address select, 0=PC, 1=ALUOut.
- `MemWrite` out 1: write strobe.
- `IRWrite` out 1: load the instruction register and OldPC.
- `PCWrite` out 1: load PC from Result.
- `RegWrite` out 1: register-file write.
- `ResultSrc` out 2: 00=ALUOut, 01=ReadData, 10=ALUResult.
- `ALUSrcA` out 2: 00=PC, 01=OldPC, 10=rs1, 11=zero.
- `ALUSrcB` out 2: 00=rs2, 01=imm, 10=4.
- `ImmSrc` out 3: immediate format, decoded from `op` (I/S/B/J/U).
- `ALUControl` out 4: ALU operation.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `trap` out 1: set while in TRAP.
- `bus_fault` out 1: trap cause is a timeout.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, UEXEC, JAL, JALR, LINK, BRANCH, TRAP.
- **Output decode:** all outputs are Moore, decoded from state. The exceptions are the `PCWrite` and `IRWrite` gating and the BRANCH `PCWrite`, which are combinational.
- **FETCH:** `mem_req`=1, `AdrSrc`=0, ALU computes PC+4 (A=00, B=10, add), `ResultSrc`=10. `IRWrite` and `PCWrite` equal `mem_ready`. Stay in FETCH until `mem_ready`, then go to DECODE.
- **DECODE:** ALU computes OldPC+imm (A=01, B=01), giving the branch/JAL target in ALUOut. Dispatch on `op`:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 0110111 / 0010111 → UEXEC
  - 1101111 → JAL
  - 1100111 → JALR
  - 1100011 → BRANCH
  - anything else → TRAP
- **Loads and stores:**
  - MEMADR computes rs1+imm, then goes to MEMRD (load) or MEMWR (store).
  - MEMRD: `mem_req`=1, `AdrSrc`=1. Hold until `mem_ready`, then go to MEMWB.
  - MEMWB: `ResultSrc`=01, `RegWrite`=1.
  - MEMWR: `mem_req`=1, `AdrSrc`=1, `MemWrite`=1, held stable until `mem_ready`.
- **ALU instructions:**
  - EXECR uses A=10, B=00; EXECI uses A=10, B=01. Both use ALUOp=funct and go to ALUWB.
  - UEXEC: A=11 if `op[5]`=1 (LUI), else 01 (AUIPC); B=01; add; go to ALUWB.
  - ALUWB: `ResultSrc`=00, `RegWrite`=1.
- **Jumps:**
  - JAL: `ResultSrc`=00, `PCWrite`=1, ALU computes OldPC+4, then ALUWB.
  - JALR: ALU computes rs1+imm, `ResultSrc`=10, `PCWrite`=1, then LINK.
  - LINK: ALU computes OldPC+4, then ALUWB.
- **BRANCH:** A=10, B=00, subtract, `ResultSrc`=00. `PCWrite`=taken, where taken is:
  - beq: Z; bne: !Z
  - blt: N^V; bge: !(N^V)
  - bltu: !C; bgeu: C
  - funct3 010/011 → TRAP instead of FETCH
- **Retire:** `instr_done`=1 in the last cycle of MEMWB, MEMWR (with `mem_ready`), ALUWB and BRANCH. Each of these states then goes to FETCH.
- **ALUControl:** ALUOp is 00=add, 01=sub, 10=funct-decoded; `ALUControl` = alu_decoder(`op[5]`, `funct3`, `funct7b5`, ALUOp).
- **TRAP:** absorbing; only `reset` exits. In TRAP, all strobes (`mem_req`, `MemWrite`, `IRWrite`, `PCWrite`, `RegWrite`) are 0 and `trap`=1.

## Timing
- **Reset:** the cycle after a `reset` edge, state=FETCH, wait counter=0, `bus_fault`=0, and all strobes are 0 while `reset`=1.
- **Reset mid-instruction:** an in-flight access is abandoned without any write strobe after the edge.
- **Latency with `mem_ready` tied high:**
  - R/I/U: 4 cycles
  - branch: 3 cycles
  - load: 5 cycles
  - store: 4 cycles
  - JAL: 4 cycles
  - JALR: 5 cycles
- Each wait cycle in FETCH, MEMRD or MEMWR adds one cycle.
- **Handshake:**
  - A transfer completes on the edge where `mem_req`&`mem_ready`.
  - `mem_ready` outside memory states is ignored.
  - Address and `MemWrite` are stable for the whole request.

## Configuration
- **`MEM_TIMEOUT_EN` defined:** a `TIMEOUT_W`-bit counter increments each cycle of `mem_req`&!`mem_ready` and clears on completion or on leaving a memory state. When the counter equals `MEM_TIMEOUT` and `mem_ready`=0, the next state is TRAP with `bus_fault`=1. If `mem_ready` arrives in that same cycle, completion wins.
- **Undefined:** there is no counter, the FSM waits indefinitely, and `bus_fault` is tied 0.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum (4-bit)
  - opcode constants
  - ALUOp codes
  - the `ResultSrc`, `ALUSrcA` and `ALUSrcB` encodings
  - the flag bit indices
- One sub-module: `alu_decoder`, instantiated for `ALUControl`.
- The next-state logic, state register, counter and branch evaluation live in the top module.

## Test plan
- Reset, then add (`op`=0110011), `mem_ready`=1 → FETCH, DECODE, EXECR, ALUWB; `RegWrite` in cycle 4; `instr_done` pulse; back to FETCH.
- lw with `mem_ready` low for 3 cycles in MEMRD → `mem_req`/`AdrSrc`=1 held for 4 cycles; `RegWrite` with `ResultSrc`=01; total 8 cycles.
- beq with `flags`=0001 → `PCWrite`=1 in BRANCH; `flags`=0000 → `PCWrite`=0; bltu with C=0 → taken.
- JALR → `PCWrite` in JALR with `ResultSrc`=10; LINK, then ALUWB with `RegWrite`; 5 cycles.
- `op`=0000000 → TRAP in the 3rd cycle, `trap`=1, no strobes for 20 cycles; `reset` → FETCH.
- `MEM_TIMEOUT_EN`, `MEM_TIMEOUT`=3, `mem_ready`=0 in FETCH → TRAP with `bus_fault`=1. A separate case with `mem_ready` arriving exactly at count 3 → normal DECODE.
